// File: rtl/udp_arb_pkg.sv
// Shared definitions for the UDP arbitration blocks: FSM state encoding and
// the round-robin pick function.
package udp_arb_pkg;

   localparam int MAX_REQ = 8;
   localparam int PTR_W   = 3;

   typedef enum logic [1:0] {
      IDLE,
      META,
      DATA
   } arb_state_t;

   typedef struct packed {
      logic             found;
      logic [PTR_W-1:0] idx;
   } rr_pick_t;

   // Pick the first set bit at or after ptr, searching upward modulo n_req.
   function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid_vec,
                                        input logic [PTR_W-1:0]   ptr,
                                        input int                 n_req);
      rr_pick_t         res;
      int               cand;
      logic [PTR_W-1:0] ci;
      res = '0;
      for (int off = 0; off < MAX_REQ; off++) begin
         if (off < n_req) begin
            cand = (int'(ptr) + off) % n_req;
            ci   = PTR_W'(cand);
            if (!res.found && valid_vec[ci]) begin
               res.found = 1'b1;
               res.idx   = ci;
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N_REQ-wide round-robin picker, shared by the TX arbiter and
// future RX demux / RoCE paths.
module rr_arbiter
   import udp_arb_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic             found,
   output logic [PTR_W-1:0] idx
);

   logic [MAX_REQ-1:0] req_ext;
   rr_pick_t           pick;

   // Widen the request vector to the package width and run the pick.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      req_ext             = '0;
      req_ext[N_REQ-1:0]  = req;
      pick                = rr_pick(req_ext, ptr, N_REQ);
   end

   assign found = pick.found;
   assign idx   = pick.idx;

endmodule

// File: rtl/udp_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the UDP stack TX metadata and
// data interfaces between N_REQ requesters. The grant is taken when metadata
// is accepted and released on the tlast beat of the matching payload.
module udp_tx_arbiter
   import udp_arb_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int META_WIDTH = 176,
   parameter int WIDTH      = 64
) (
   input  logic                              net_clk,
   input  logic                              net_rst,
   input  logic [N_REQ-1:0]                  s_meta_valid,
   output logic [N_REQ-1:0]                  s_meta_ready,
   input  logic [N_REQ*META_WIDTH-1:0]       s_meta_data,
   input  logic [N_REQ-1:0]                  s_data_valid,
   output logic [N_REQ-1:0]                  s_data_ready,
   input  logic [N_REQ*WIDTH-1:0]            s_data_data,
   input  logic [N_REQ*(WIDTH/8)-1:0]        s_data_keep,
   input  logic [N_REQ-1:0]                  s_data_last,
   output logic                              m_meta_valid,
   input  logic                              m_meta_ready,
   output logic [META_WIDTH-1:0]             m_meta_data,
   output logic                              m_data_valid,
   input  logic                              m_data_ready,
   output logic [WIDTH-1:0]                  m_data_data,
   output logic [WIDTH/8-1:0]                m_data_keep,
   output logic                              m_data_last,
   output logic [N_REQ-1:0]                  grant,
   output logic [31:0]                       pkt_count
);

   localparam int KEEP_W = WIDTH / 8;

   arb_state_t            state;
   logic [PTR_W-1:0]      rr_ptr;
   logic [PTR_W-1:0]      gidx;
   logic [PTR_W-1:0]      win_idx;
   logic                  win_found;
   logic [N_REQ-1:0]      win_onehot;
   logic [META_WIDTH-1:0] meta_sel;
   logic                  in_idle;
   logic                  in_data;
   logic                  last_fire;
   logic [PTR_W-1:0]      next_ptr;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req   (s_meta_valid),
      .ptr   (rr_ptr),
      .found (win_found),
      .idx   (win_idx)
   );

   assign in_idle = (state == IDLE) && !net_rst;
   assign in_data = (state == DATA) && !net_rst;

   // Decode the winning index to one-hot and select its metadata word.
   always_comb begin
      win_onehot = '0;
      meta_sel   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_found && (win_idx == PTR_W'(i))) begin
            win_onehot[i] = 1'b1;
            meta_sel      = s_meta_data[i*META_WIDTH +: META_WIDTH];
         end
      end
   end

   // The metadata input handshake completes in IDLE, in the arbitration cycle.
   assign s_meta_ready = in_idle ? win_onehot : '0;

   // Route the granted requester's data straight through, no added latency.
   always_comb begin
      m_data_data = '0;
      m_data_keep = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            m_data_data = s_data_data[i*WIDTH +: WIDTH];
            m_data_keep = s_data_keep[i*KEEP_W +: KEEP_W];
         end
      end
      m_data_valid = in_data && |(s_data_valid & grant);
      m_data_last  = in_data && |(s_data_last & grant);
      s_data_ready = in_data ? (grant & {N_REQ{m_data_ready}}) : '0;
   end

   assign last_fire = m_data_valid && m_data_ready && m_data_last;
   assign next_ptr  = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;

   // Arbitration FSM with registered grant, metadata valid and packet count.
   always_ff @(posedge net_clk) begin
      if (net_rst) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         gidx         <= '0;
         grant        <= '0;
         m_meta_valid <= 1'b0;
         pkt_count    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  grant        <= win_onehot;
                  gidx         <= win_idx;
                  m_meta_valid <= 1'b1;
                  state        <= META;
               end
            end
            META: begin
               if (m_meta_ready) begin
                  m_meta_valid <= 1'b0;
                  state        <= DATA;
               end
            end
            DATA: begin
               if (last_fire) begin
                  pkt_count <= pkt_count + 32'd1;
                  rr_ptr    <= next_ptr;
                  grant     <= '0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Capture the winner's metadata; held stable through META.
   always_ff @(posedge net_clk) begin
      // NOTE: datapath register left without reset; m_meta_valid qualifies it.
      if ((state == IDLE) && win_found) begin
         m_meta_data <= meta_sel;
      end
   end

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Shares the single UDP TX role interface (tx metadata + tx data) of the UDP stack between N independent requesters.
- Round-robin arbitration at packet granularity. A grant is held from metadata acceptance until the tlast beat of the matching payload.
- Sits between the user roles and the UDP stack's s_axis_udp_tx_metadata / s_axis_udp_tx_data in the net_clk domain.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- META_WIDTH, 176, width of a UDP tx metadata word.
- WIDTH, 64, data beat width; keep width is WIDTH/8.

Ports:
- net_clk  in  1  clock; all logic on rising edge.
- net_rst  in  1  synchronous active-high reset.
- s_meta_valid  in  N_REQ  per-requester metadata valid.
- s_meta_ready  out  N_REQ  per-requester metadata ready.
- s_meta_data  in  N_REQ*META_WIDTH  requester i at slice [i*META_WIDTH +: META_WIDTH].
- s_data_valid  in  N_REQ  per-requester data valid.
- s_data_ready  out  N_REQ  per-requester data ready.
- s_data_data  in  N_REQ*WIDTH  packed payload.
- s_data_keep  in  N_REQ*WIDTH/8  packed keep.
- s_data_last  in  N_REQ  per-requester last.
- m_meta_valid / m_meta_ready / m_meta_data  out/in/out  1/1/META_WIDTH  to UDP stack tx metadata.
- m_data_valid / m_data_ready  out/in  1/1  to UDP stack tx data.
- m_data_data / m_data_keep / m_data_last  out  WIDTH / WIDTH/8 / 1  to UDP stack tx data.
- grant  out  N_REQ  one-hot current owner; 0 in IDLE.
- pkt_count  out  32  packets completed (tlast handshakes on m_data); wraps at 2^32.

Behaviour:
- Reset:
  - state=IDLE, rr pointer=0, grant=0, pkt_count=0.
  - All valid/ready outputs 0; m_meta_data and m_data_* are don't-care.
  - A reset mid-packet abandons the packet silently. No partial tlast is generated.
- IDLE:
  - Candidates are the indices with s_meta_valid set.
  - Winner is the first candidate at or after rr pointer, searching upward modulo N_REQ.
  - On winner: capture s_meta_data into the meta output register.
  - Pulse s_meta_ready[winner] for exactly that cycle, so the input handshake completes in IDLE.
  - Set grant, go to META. m_meta_valid rises on the next cycle (1-cycle latency).
  - No candidates: stay in IDLE.
- META:
  - Hold m_meta_valid=1 with stable data until m_meta_ready.
  - On handshake, go to DATA.
  - All s_meta_ready=0; all s_data_ready=0.
- DATA:
  - Combinational mux from the granted port to m_data_*.
  - m_data_valid = s_data_valid[g]; s_data_ready[g] = m_data_ready; all other s_data_ready=0.
  - No added data latency.
  - On a beat with valid & ready & last: pkt_count += 1, rr pointer = g+1 mod N_REQ, grant=0, go to IDLE.
  - Back-to-back packets therefore incur 2 bubble cycles: the IDLE cycle and the META cycle.
- Data from a port arriving before its grant is stalled (ready low), never dropped.
- Metadata from non-winning ports waits with ready low.
- Every packet has at least one data beat. Zero-length packets are not supported.
- A requester holding valid is guaranteed service within N_REQ-1 other packets.
- Keep passes through unmodified; no width conversion.

Decomposition:
- Shared package (udp_arb_pkg) holds:
  - typedef enum arb_state_t {IDLE, META, DATA};
  - function rr_pick(valid_vector, pointer) returning index plus found flag.
- One sub-module is natural: rr_arbiter (N_REQ-wide combinational round-robin pick).
  - Reusable by the future RX demux and by the RoCE path.
- All remaining logic lives in udp_tx_arbiter.

Test Plan:
- Single requester: port 2 sends meta 0xA5... then 3 beats (last on beat 3), with m ready always high.
  - m_meta_valid appears 1 cycle after s_meta handshake.
  - 3 data beats appear identical to the input.
  - grant=0b0100 throughout; pkt_count=1; rr pointer=3.
- Contention: ports 0,1,3 all assert meta+data simultaneously after reset, 2-beat packets each.
  - Service order is 0,1,3, then 0 again if re-requested.
  - No interleaving of beats from different ports; pkt_count=3.
- Backpressure:
  - m_meta_ready low 5 cycles: m_meta_data stable, no data accepted.
  - Then m_data_ready toggles 1/0 during a 4-beat packet: s_data_ready[g] mirrors m_data_ready each cycle and no beat is lost or duplicated.
- Early data: port 1 drives data valid 10 cycles before its meta valid.
  - s_data_ready[1]=0 until grant; the packet is then transferred intact.
- Reset mid-packet: assert net_rst on beat 2 of 4.
  - The next cycle: all valid/ready=0, grant=0, pkt_count=0.
  - After release, a new arbitration starts from port 0.
- Counter wrap: preload pkt_count=0xFFFF_FFFF via force, complete one packet -> pkt_count=0.
